// File: rtl/stencil_fetch.sv
// Read-side sequencer: walks interior grid cells row-major, fetches the 5-point stencil
// (C, N, S, W, E) from a 1-cycle-latency RAM and presents it on a valid/ready stream.
module stencil_fetch #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned GRID_W        = 50,
  parameter int unsigned GRID_H        = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_idx,
  output logic [DATA_WIDTH-1:0]    out_c,
  output logic [DATA_WIDTH-1:0]    out_n,
  output logic [DATA_WIDTH-1:0]    out_s,
  output logic [DATA_WIDTH-1:0]    out_w,
  output logic [DATA_WIDTH-1:0]    out_e,
  output logic                     out_last
);

  localparam logic [ADDRESS_WIDTH-1:0] GridW   = ADDRESS_WIDTH'(GRID_W);
  localparam logic [ADDRESS_WIDTH-1:0] LastCol = ADDRESS_WIDTH'(GRID_W - 2);
  localparam logic [ADDRESS_WIDTH-1:0] LastRow = ADDRESS_WIDTH'(GRID_H - 2);
  localparam logic [ADDRESS_WIDTH-1:0] One     = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] FirstIdx = ADDRESS_WIDTH'(GRID_W + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               phase_q, phase_d;
  logic [ADDRESS_WIDTH-1:0] row_q, row_d;
  logic [ADDRESS_WIDTH-1:0] col_q, col_d;
  logic [ADDRESS_WIDTH-1:0] ctr_q, ctr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     last_q, last_d;
  logic [DATA_WIDTH-1:0]    slot_q [5];
  logic [DATA_WIDTH-1:0]    slot_d [5];

  // Read address for fetch phase p of the stencil centred on ctr (order C, N, S, W, E).
  function automatic logic [ADDRESS_WIDTH-1:0] nbr_addr(input logic [2:0] p,
                                                        input logic [ADDRESS_WIDTH-1:0] ctr);
    logic [ADDRESS_WIDTH-1:0] a;
    case (p)
      3'd1:    a = ctr - GridW;
      3'd2:    a = ctr + GridW;
      3'd3:    a = ctr - One;
      3'd4:    a = ctr + One;
      default: a = ctr;
    endcase
    return a;
  endfunction

  // State and datapath registers; reset clears every output-visible register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= 3'd0;
      row_q   <= One;
      col_q   <= One;
      ctr_q   <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < 5; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ctr_q   <= ctr_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      for (int i = 0; i < 5; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Next-state logic: sequencing of reads, captures and cell advance.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    row_d   = row_q;
    col_d   = col_q;
    ctr_d   = ctr_q;
    addr_d  = addr_q;
    last_d  = last_q;
    for (int i = 0; i < 5; i++) slot_d[i] = slot_q[i];

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          phase_d = 3'd0;
          row_d   = One;
          col_d   = One;
          ctr_d   = FirstIdx;
          addr_d  = FirstIdx;
          last_d  = 1'b0;
        end
      end
      StFetch: begin
        // Address of read p+1 goes out while data of read p-1 returns.
        if (phase_q < 3'd4) addr_d = nbr_addr(phase_q + 3'd1, ctr_q);
        if (phase_q != 3'd0) slot_d[phase_q - 3'd1] = ram_rd_data;
        if (phase_q == 3'd5) begin
          state_d = StPresent;
          last_d  = (row_q == LastRow) && (col_q == LastCol);
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      StPresent: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = StDone;
            last_d  = 1'b0;
          end else begin
            state_d = StFetch;
            phase_d = 3'd0;
            if (col_q == LastCol) begin
              // Skip the right boundary of this row and the left boundary of the next.
              col_d = One;
              row_d = row_q + One;
              ctr_d = ctr_q + ADDRESS_WIDTH'(3);
            end else begin
              col_d = col_q + One;
              ctr_d = ctr_q + One;
            end
            addr_d = ctr_d;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        row_d   = One;
        col_d   = One;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy      = (state_q == StFetch) || (state_q == StPresent);
    done      = (state_q == StDone);
    out_valid = (state_q == StPresent);
    ram_addr  = addr_q;
    out_idx   = ctr_q;
    out_last  = last_q;
    out_c     = slot_q[0];
    out_n     = slot_q[1];
    out_s     = slot_q[2];
    out_w     = slot_q[3];
    out_e     = slot_q[4];
  end

endmodule
